song_recorder: RTL and testbench

- Writer end of the note-lane interface: records player key presses, one slot per beat, into three 100-slot lanes (red, yellow, blue).
- Plays the recorded song back as left-shifting 26-bit lane windows. Bit 25 is the "note now" slot, matching what the drawing and hit-judging logic consume.
- Sits between the inverted KEY[2:0] inputs and the renderer/player_control. It replaces the hard-coded lane patterns with user-authored songs.

---
 rtl/song_recorder.sv | 178 +++++++++++++++++
 tb/tb_song_recorder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_recorder.sv
// Note-lane writer: records key presses one slot per beat into three lanes,
// then plays them back as left-shifting windows whose MSB is the hit slot.
module song_recorder #(
   parameter int SONG_LEN = 100,
   parameter int WINDOW   = 26,
   parameter int LEN_W    = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              beat_tick,
   input  logic [2:0]        keys,
   input  logic              record_start,
   input  logic              record_stop,
   input  logic              play_start,
   output logic [WINDOW-1:0] out_red,
   output logic [WINDOW-1:0] out_yellow,
   output logic [WINDOW-1:0] out_blue,
   output logic [LEN_W-1:0]  song_len,
   output logic              recording,
   output logic              playing,
   output logic              done_pulse
);

   typedef enum logic [1:0] {S_IDLE, S_REC, S_DONE, S_PLAY} state_t;

   localparam logic [LEN_W-1:0]    LEN_MAX  = LEN_W'(SONG_LEN);
   localparam logic [SONG_LEN-1:0] TOP_SLOT = {1'b1, {(SONG_LEN-1){1'b0}}};

   state_t              state_q, state_d;
   logic [SONG_LEN-1:0] lane_r_q, lane_r_d, lane_y_q, lane_y_d, lane_b_q, lane_b_d;
   logic [SONG_LEN-1:0] sh_r_q, sh_r_d, sh_y_q, sh_y_d, sh_b_q, sh_b_d;
   logic [2:0]          keys_q, pend_q, pend_d;
   logic [LEN_W-1:0]    wr_ptr_q, wr_ptr_d, play_cnt_q, play_cnt_d, len_q, len_d;
   logic                done_q, done_d;

   logic [2:0]          key_edge, cap;
   logic [SONG_LEN-1:0] slot_mask;
   logic [LEN_W-1:0]    wr_next, play_next;

   // A press coinciding with the beat still lands in the current slot.
   assign key_edge  = keys & ~keys_q;
   assign cap       = pend_q | key_edge;
   assign slot_mask = TOP_SLOT >> wr_ptr_q;
   assign wr_next   = wr_ptr_q + LEN_W'(1);
   assign play_next = play_cnt_q + LEN_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         lane_r_q   <= '0;
         lane_y_q   <= '0;
         lane_b_q   <= '0;
         sh_r_q     <= '0;
         sh_y_q     <= '0;
         sh_b_q     <= '0;
         keys_q     <= '0;
         pend_q     <= '0;
         wr_ptr_q   <= '0;
         play_cnt_q <= '0;
         len_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_r_q   <= lane_r_d;
         lane_y_q   <= lane_y_d;
         lane_b_q   <= lane_b_d;
         sh_r_q     <= sh_r_d;
         sh_y_q     <= sh_y_d;
         sh_b_q     <= sh_b_d;
         keys_q     <= keys;
         pend_q     <= pend_d;
         wr_ptr_q   <= wr_ptr_d;
         play_cnt_q <= play_cnt_d;
         len_q      <= len_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lane_r_d   = lane_r_q;
      lane_y_d   = lane_y_q;
      lane_b_d   = lane_b_q;
      sh_r_d     = sh_r_q;
      sh_y_d     = sh_y_q;
      sh_b_d     = sh_b_q;
      pend_d     = pend_q;
      wr_ptr_d   = wr_ptr_q;
      play_cnt_d = play_cnt_q;
      len_d      = len_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (record_start) begin
               state_d  = S_REC;
               lane_r_d = '0;
               lane_y_d = '0;
               lane_b_d = '0;
               wr_ptr_d = '0;
               pend_d   = '0;
            end
         end

         S_REC: begin
            if (beat_tick) begin
               lane_r_d = (lane_r_q & ~slot_mask) | (slot_mask & {SONG_LEN{cap[2]}});
               lane_y_d = (lane_y_q & ~slot_mask) | (slot_mask & {SONG_LEN{cap[1]}});
               lane_b_d = (lane_b_q & ~slot_mask) | (slot_mask & {SONG_LEN{cap[0]}});
               pend_d   = '0;
               wr_ptr_d = wr_next;
               if (wr_next == LEN_MAX || record_stop) begin
                  len_d   = wr_next;
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end else if (record_stop) begin
               len_d   = wr_ptr_q;
               pend_d  = '0;
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               pend_d = cap;
            end
         end

         S_DONE: begin
            if (record_start) begin
               state_d  = S_REC;
               lane_r_d = '0;
               lane_y_d = '0;
               lane_b_d = '0;
               wr_ptr_d = '0;
               pend_d   = '0;
            end else if (play_start && len_q != '0) begin
               state_d    = S_PLAY;
               sh_r_d     = lane_r_q;
               sh_y_d     = lane_y_q;
               sh_b_d     = lane_b_q;
               play_cnt_d = '0;
            end
         end

         S_PLAY: begin
            // Shift copies are zeroed on every exit so the windows read 0 outside PLAY.
            if (record_stop) begin
               state_d = S_DONE;
               sh_r_d  = '0;
               sh_y_d  = '0;
               sh_b_d  = '0;
            end else if (beat_tick) begin
               sh_r_d     = sh_r_q << 1;
               sh_y_d     = sh_y_q << 1;
               sh_b_d     = sh_b_q << 1;
               play_cnt_d = play_next;
               if (play_next == len_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  sh_r_d  = '0;
                  sh_y_d  = '0;
                  sh_b_d  = '0;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign out_red    = sh_r_q[SONG_LEN-1 -: WINDOW];
   assign out_yellow = sh_y_q[SONG_LEN-1 -: WINDOW];
   assign out_blue   = sh_b_q[SONG_LEN-1 -: WINDOW];
   assign song_len   = len_q;
   assign recording  = (state_q == S_REC);
   assign playing    = (state_q == S_PLAY);
   assign done_pulse = done_q;

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder: per-cycle vector table plus hand-written
// multi-cycle sequences for full-length songs, collisions, empty songs and reset.
module tb_song_recorder;

   logic        clk = 1'b0;
   logic        reset;
   logic        beat_tick;
   logic [2:0]  keys;
   logic        record_start;
   logic        record_stop;
   logic        play_start;
   logic [25:0] out_red;
   logic [25:0] out_yellow;
   logic [25:0] out_blue;
   logic [6:0]  song_len;
   logic        recording;
   logic        playing;
   logic        done_pulse;

   int total = 0;
   int bad   = 0;

   song_recorder #(.SONG_LEN(100), .WINDOW(26), .LEN_W(7)) dut (
      .clk         (clk),
      .reset       (reset),
      .beat_tick   (beat_tick),
      .keys        (keys),
      .record_start(record_start),
      .record_stop (record_stop),
      .play_start  (play_start),
      .out_red     (out_red),
      .out_yellow  (out_yellow),
      .out_blue    (out_blue),
      .song_len    (song_len),
      .recording   (recording),
      .playing     (playing),
      .done_pulse  (done_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        t;
      logic [2:0]  k;
      logic        rs, rp, ps;
      logic        e_rec, e_ply, e_dn;
      logic [6:0]  e_len;
      logic [25:0] e_r, e_y, e_b;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic t, input logic [2:0] k, input logic rs,
                               input logic rp, input logic ps, input logic e_rec,
                               input logic e_ply, input logic e_dn, input logic [6:0] e_len,
                               input logic [25:0] e_r, input logic [25:0] e_y,
                               input logic [25:0] e_b);
      vec_t v;
      v.t = t; v.k = k; v.rs = rs; v.rp = rp; v.ps = ps;
      v.e_rec = e_rec; v.e_ply = e_ply; v.e_dn = e_dn; v.e_len = e_len;
      v.e_r = e_r; v.e_y = e_y; v.e_b = e_b;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic t, input logic [2:0] k, input logic rs,
                        input logic rp, input logic ps);
      beat_tick    = t;
      keys         = k;
      record_start = rs;
      record_stop  = rp;
      play_start   = ps;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [25:0] exp_b;

      // basic record/play: red slot 0, blue slot 2, yellow slot 3 (coincident)
      add(0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 26'h0, 26'h0, 26'h0);
      add(0, 3'b100, 0, 0, 0, 1, 0, 0, 0, 26'h0, 26'h0, 26'h0);
      add(1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 26'h0, 26'h0, 26'h0);
      add(1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 26'h0, 26'h0, 26'h0);
      add(0, 3'b001, 0, 0, 0, 1, 0, 0, 0, 26'h0, 26'h0, 26'h0);
      add(1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 26'h0, 26'h0, 26'h0);
      add(1, 3'b010, 0, 0, 0, 1, 0, 0, 0, 26'h0, 26'h0, 26'h0);
      add(0, 3'b000, 0, 1, 0, 0, 0, 1, 4, 26'h0, 26'h0, 26'h0);
      add(0, 3'b000, 0, 0, 0, 0, 0, 0, 4, 26'h0, 26'h0, 26'h0);
      add(0, 3'b000, 0, 0, 1, 0, 1, 0, 4, 26'h2000000, 26'h0400000, 26'h0800000);
      add(1, 3'b000, 0, 0, 0, 0, 1, 0, 4, 26'h0,       26'h0800000, 26'h1000000);
      add(1, 3'b000, 0, 0, 0, 0, 1, 0, 4, 26'h0,       26'h1000000, 26'h2000000);
      add(1, 3'b000, 0, 0, 0, 0, 1, 0, 4, 26'h0,       26'h2000000, 26'h0);
      add(1, 3'b000, 0, 0, 0, 0, 0, 1, 4, 26'h0, 26'h0, 26'h0);
      add(0, 3'b000, 0, 0, 0, 0, 0, 0, 4, 26'h0, 26'h0, 26'h0);
      // held red across 5 ticks: only slot 0 set; old lanes must be gone
      add(0, 3'b000, 1, 0, 0, 1, 0, 0, 4, 26'h0, 26'h0, 26'h0);
      add(0, 3'b100, 0, 0, 0, 1, 0, 0, 4, 26'h0, 26'h0, 26'h0);
      for (int i = 0; i < 5; i++)
         add(1, 3'b100, 0, 0, 0, 1, 0, 0, 4, 26'h0, 26'h0, 26'h0);
      add(0, 3'b000, 0, 1, 0, 0, 0, 1, 5, 26'h0, 26'h0, 26'h0);
      add(0, 3'b000, 0, 0, 1, 0, 1, 0, 5, 26'h2000000, 26'h0, 26'h0);
      for (int i = 0; i < 4; i++)
         add(1, 3'b000, 0, 0, 0, 0, 1, 0, 5, 26'h0, 26'h0, 26'h0);
      add(1, 3'b000, 0, 0, 0, 0, 0, 1, 5, 26'h0, 26'h0, 26'h0);

      reset = 1'b1;
      drive(0, 3'b000, 0, 0, 0);
      #1;
      chk("reset rec", {31'd0, recording}, 0);
      chk("reset len", {25'd0, song_len}, 0);
      chk("reset outs", {6'd0, out_red | out_yellow | out_blue}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].t, tbl[i].k, tbl[i].rs, tbl[i].rp, tbl[i].ps);
         step();
         chk($sformatf("vec%0d recording", i), {31'd0, recording},  {31'd0, tbl[i].e_rec});
         chk($sformatf("vec%0d playing", i),   {31'd0, playing},    {31'd0, tbl[i].e_ply});
         chk($sformatf("vec%0d done_pulse", i),{31'd0, done_pulse}, {31'd0, tbl[i].e_dn});
         chk($sformatf("vec%0d song_len", i),  {25'd0, song_len},   {25'd0, tbl[i].e_len});
         chk($sformatf("vec%0d out_red", i),   {6'd0, out_red},     {6'd0, tbl[i].e_r});
         chk($sformatf("vec%0d out_yellow", i),{6'd0, out_yellow},  {6'd0, tbl[i].e_y});
         chk($sformatf("vec%0d out_blue", i),  {6'd0, out_blue},    {6'd0, tbl[i].e_b});
      end

      // full 100-slot song, blue on every 4th slot, auto-finish
      drive(0, 3'b000, 1, 0, 0);
      step();
      chk("full rec start", {31'd0, recording}, 1);
      for (int i = 0; i < 100; i++) begin
         if (i % 4 == 0) begin
            drive(0, 3'b001, 0, 0, 0);
            step();
         end
         drive(1, 3'b000, 0, 0, 0);
         step();
         if (i == 98) chk("full rec before last", {31'd0, recording}, 1);
      end
      chk("full auto done", {31'd0, done_pulse}, 1);
      chk("full auto len", {25'd0, song_len}, 100);
      chk("full auto rec off", {31'd0, recording}, 0);
      drive(0, 3'b000, 0, 0, 0);
      step();
      chk("full done one cycle", {31'd0, done_pulse}, 0);
      drive(0, 3'b000, 0, 0, 1);
      step();
      drive(0, 3'b000, 0, 0, 0);
      for (int k = 0; k < 100; k++) begin
         exp_b = '0;
         for (int j = 0; j < 26; j++)
            if ((k + j) < 100 && ((k + j) % 4) == 0) exp_b[25-j] = 1'b1;
         chk($sformatf("full play%0d blue", k), {6'd0, out_blue}, {6'd0, exp_b});
         chk($sformatf("full play%0d playing", k), {31'd0, playing}, 1);
         drive(1, 3'b000, 0, 0, 0);
         step();
      end
      chk("full play done", {31'd0, done_pulse}, 1);
      chk("full play off", {31'd0, playing}, 0);
      chk("full play outs 0", {6'd0, out_red | out_yellow | out_blue}, 0);

      // record_stop together with beat_tick at wr_ptr=9
      drive(0, 3'b000, 1, 0, 0);
      step();
      for (int i = 0; i < 9; i++) begin
         drive(1, 3'b000, 0, 0, 0);
         step();
      end
      drive(1, 3'b100, 0, 1, 0);
      step();
      chk("coll done", {31'd0, done_pulse}, 1);
      chk("coll len", {25'd0, song_len}, 10);
      drive(0, 3'b000, 0, 0, 0);
      step();
      drive(0, 3'b000, 0, 0, 1);
      step();
      chk("coll play first red", {6'd0, out_red}, {6'd0, 26'h0010000});
      for (int i = 0; i < 9; i++) begin
         drive(1, 3'b000, 0, 0, 0);
         step();
      end
      chk("coll slot9 red", {6'd0, out_red}, {6'd0, 26'h2000000});
      chk("coll still playing", {31'd0, playing}, 1);
      drive(1, 3'b000, 0, 0, 0);
      step();
      chk("coll play done", {31'd0, done_pulse}, 1);
      chk("coll play off", {31'd0, playing}, 0);

      // empty song, ignored play, re-record clears lanes, abort without pulse
      drive(0, 3'b000, 1, 0, 0);
      step();
      chk("empty rec", {31'd0, recording}, 1);
      drive(0, 3'b000, 0, 1, 0);
      step();
      chk("empty len", {25'd0, song_len}, 0);
      chk("empty done", {31'd0, done_pulse}, 1);
      drive(0, 3'b000, 0, 0, 1);
      step();
      chk("empty play ignored", {31'd0, playing}, 0);
      drive(0, 3'b000, 1, 0, 0);
      step();
      chk("empty re-rec", {31'd0, recording}, 1);
      for (int i = 0; i < 10; i++) begin
         drive(1, 3'b000, 0, 0, 0);
         step();
      end
      drive(0, 3'b000, 0, 1, 0);
      step();
      chk("rerec len", {25'd0, song_len}, 10);
      drive(0, 3'b000, 0, 0, 1);
      step();
      chk("rerec playing", {31'd0, playing}, 1);
      chk("rerec lanes cleared", {6'd0, out_red | out_yellow | out_blue}, 0);
      drive(0, 3'b000, 0, 1, 0);
      step();
      chk("abort playing", {31'd0, playing}, 0);
      chk("abort no pulse", {31'd0, done_pulse}, 0);

      // reset mid-PLAY clears everything immediately
      drive(0, 3'b000, 0, 0, 1);
      step();
      chk("pre-reset playing", {31'd0, playing}, 1);
      drive(1, 3'b000, 0, 0, 0);
      step();
      drive(0, 3'b000, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("async reset playing", {31'd0, playing}, 0);
      chk("async reset len", {25'd0, song_len}, 0);
      chk("async reset outs", {6'd0, out_red | out_yellow | out_blue}, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 3'b000, 0, 0, 1);
      step();
      chk("post-reset play ignored", {31'd0, playing}, 0);
      drive(0, 3'b000, 0, 0, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
